// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use/branch stalls and multiply-busy FSM.
// Optional multiply watchdog enabled by defining MULT_TIMEOUT_EN (adds MultTimeout port).
module hazard_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic [4:0] RsE,
  input  logic [4:0] RtE,
  input  logic [4:0] WriteRegE,
  input  logic [4:0] WriteRegM,
  input  logic [4:0] WriteRegW,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemToRegE,
  input  logic       MemToRegM,
  input  logic       BranchD,
  input  logic       MultStartE,
  input  logic       MultComplete,
  input  logic       HiLoReadD,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE,
  output logic       forwardAD,
  output logic       forwardBD,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushE,
  output logic       FlushM,
  output logic       MultBusy
`ifdef MULT_TIMEOUT_EN
  ,
  output logic       MultTimeout
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state;
  logic   lwstall;
  logic   brstall;
  logic   mult_term;
  logic   multstall;

`ifdef MULT_TIMEOUT_EN
  logic [5:0] cnt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      MultBusy <= 1'b0;
`ifdef MULT_TIMEOUT_EN
      cnt         <= '0;
      MultTimeout <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (MultStartE) begin
            if (MultComplete) begin
              state <= DONE;
            end else begin
              state    <= BUSY;
              MultBusy <= 1'b1;
`ifdef MULT_TIMEOUT_EN
              cnt <= '0;
`endif
            end
          end
        end
        BUSY: begin
          if (MultComplete) begin
            state    <= DONE;
            MultBusy <= 1'b0;
`ifdef MULT_TIMEOUT_EN
          // completion wins over a watchdog expiry in the same cycle
          end else if (cnt == 6'd47) begin
            state       <= IDLE;
            MultBusy    <= 1'b0;
            MultTimeout <= 1'b1;
          end else begin
            cnt <= cnt + 6'd1;
`endif
          end
        end
        DONE: begin
          state    <= IDLE;
          MultBusy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          MultBusy <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    forwardAE = 2'b00;
    if (RsE != 5'd0 && RegWriteM && RsE == WriteRegM)      forwardAE = 2'b10;
    else if (RsE != 5'd0 && RegWriteW && RsE == WriteRegW) forwardAE = 2'b01;

    forwardBE = 2'b00;
    if (RtE != 5'd0 && RegWriteM && RtE == WriteRegM)      forwardBE = 2'b10;
    else if (RtE != 5'd0 && RegWriteW && RtE == WriteRegW) forwardBE = 2'b01;
  end

  assign forwardAD = (RsD != 5'd0) && RegWriteM && (RsD == WriteRegM);
  assign forwardBD = (RtD != 5'd0) && RegWriteM && (RtD == WriteRegM);

  assign lwstall = MemToRegE && ((RsD == WriteRegE) || (RtD == WriteRegE));
  assign brstall = BranchD &&
                   ((RegWriteE && ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
                    (MemToRegM && ((WriteRegM == RsD) || (WriteRegM == RtD))));

  // E is held only by the multiplier itself; a HI/LO reader only freezes F/D
  assign mult_term = (state == BUSY) || (state == IDLE && MultStartE && !MultComplete);
  assign multstall = mult_term || (HiLoReadD && state != IDLE);

  assign StallF = lwstall || brstall || multstall;
  assign StallD = StallF;
  assign StallE = mult_term;
  assign FlushE = (lwstall || brstall) && !StallE;
  assign FlushM = StallE;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit: forwarding, stalls, multiply FSM and async reset.
module tb_hazard_unit;

  logic       clk;
  logic       rst;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic       RegWriteE, RegWriteM, RegWriteW, MemToRegE, MemToRegM;
  logic       BranchD, MultStartE, MultComplete, HiLoReadD;
  logic [1:0] forwardAE, forwardBE;
  logic       forwardAD, forwardBD, StallF, StallD, StallE, FlushE, FlushM, MultBusy;
`ifdef MULT_TIMEOUT_EN
  logic       MultTimeout;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;

  hazard_unit dut (
    .clk          (clk),
    .rst          (rst),
    .RsD          (RsD),
    .RtD          (RtD),
    .RsE          (RsE),
    .RtE          (RtE),
    .WriteRegE    (WriteRegE),
    .WriteRegM    (WriteRegM),
    .WriteRegW    (WriteRegW),
    .RegWriteE    (RegWriteE),
    .RegWriteM    (RegWriteM),
    .RegWriteW    (RegWriteW),
    .MemToRegE    (MemToRegE),
    .MemToRegM    (MemToRegM),
    .BranchD      (BranchD),
    .MultStartE   (MultStartE),
    .MultComplete (MultComplete),
    .HiLoReadD    (HiLoReadD),
    .forwardAE    (forwardAE),
    .forwardBE    (forwardBE),
    .forwardAD    (forwardAD),
    .forwardBD    (forwardBD),
    .StallF       (StallF),
    .StallD       (StallD),
    .StallE       (StallE),
    .FlushE       (FlushE),
    .FlushM       (FlushM),
    .MultBusy     (MultBusy)
`ifdef MULT_TIMEOUT_EN
    ,
    .MultTimeout  (MultTimeout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    RsD = '0; RtD = '0; RsE = '0; RtE = '0;
    WriteRegE = '0; WriteRegM = '0; WriteRegW = '0;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    MemToRegE = 1'b0; MemToRegM = 1'b0; BranchD = 1'b0;
    MultStartE = 1'b0; MultComplete = 1'b0; HiLoReadD = 1'b0;
  endtask

  // advance to 1 time unit past the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    #1;
    check_eq("reset_outputs",
             {4'h0, forwardAE, forwardBE, forwardAD, forwardBD, StallF, StallD,
              StallE, FlushE, FlushM, MultBusy}, 16'h0000);
    step();
    step();
    rst = 1'b0;
    step();

    // forwarding priority and register zero
    RsE = 5'd5; WriteRegM = 5'd5; RegWriteM = 1'b1; WriteRegW = 5'd5; RegWriteW = 1'b1;
    #1 check_eq("fwdA_mem_priority", 16'(forwardAE), 16'd2);
    RegWriteM = 1'b0;
    #1 check_eq("fwdA_wb", 16'(forwardAE), 16'd1);
    RegWriteW = 1'b0;
    #1 check_eq("fwdA_none", 16'(forwardAE), 16'd0);
    RsE = 5'd0; WriteRegM = 5'd0; RegWriteM = 1'b1;
    #1 check_eq("fwdA_reg_zero", 16'(forwardAE), 16'd0);
    clear_inputs();
    RtE = 5'd7; WriteRegW = 5'd7; RegWriteW = 1'b1;
    #1 check_eq("fwdB_wb", 16'(forwardBE), 16'd1);
    WriteRegM = 5'd7; RegWriteM = 1'b1;
    #1 check_eq("fwdB_mem", 16'(forwardBE), 16'd2);
    clear_inputs();
    RsD = 5'd4; RtD = 5'd9; WriteRegM = 5'd4; RegWriteM = 1'b1;
    #1 check_eq("fwdAD_BD_rs", {14'd0, forwardAD, forwardBD}, 16'b10);
    WriteRegM = 5'd9;
    #1 check_eq("fwdAD_BD_rt", {14'd0, forwardAD, forwardBD}, 16'b01);
    RsD = 5'd0; RtD = 5'd0; WriteRegM = 5'd0;
    #1 check_eq("fwdAD_BD_zero", {14'd0, forwardAD, forwardBD}, 16'b00);
    clear_inputs();

    // load-use stall for exactly one cycle
    MemToRegE = 1'b1; WriteRegE = 5'd8; RtD = 5'd8; RsD = 5'd2;
    #1 check_eq("lw_rt", {11'd0, StallF, StallD, StallE, FlushE, FlushM}, 16'b11010);
    step();
    clear_inputs();
    #1 check_eq("lw_released", {11'd0, StallF, StallD, StallE, FlushE, FlushM}, 16'b00000);
    MemToRegE = 1'b1; WriteRegE = 5'd6; RsD = 5'd6; RtD = 5'd1;
    #1 check_eq("lw_rs", {13'd0, StallD, FlushE, StallE}, 16'b110);
    MemToRegE = 1'b0;
    #1 check_eq("lw_not_load", {13'd0, StallD, FlushE, StallE}, 16'b000);
    clear_inputs();

    // branch stalls
    BranchD = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd3; RsD = 5'd3; RtD = 5'd1;
    #1 check_eq("br_alu_e", {13'd0, StallF, StallD, FlushE}, 16'b111);
    BranchD = 1'b0;
    #1 check_eq("br_not_branch", {13'd0, StallF, StallD, FlushE}, 16'b000);
    clear_inputs();
    BranchD = 1'b1; MemToRegM = 1'b1; WriteRegM = 5'd4; RsD = 5'd1; RtD = 5'd4;
    #1 check_eq("br_load_m", {13'd0, StallF, StallD, FlushE}, 16'b111);
    MemToRegM = 1'b0;
    #1 check_eq("br_no_hazard", {13'd0, StallF, StallD, FlushE}, 16'b000);
    clear_inputs();
    step();

    // multiply: start at cycle 0, complete at cycle 32
    MultStartE = 1'b1;
    #1 check_eq("mult_c0", {10'd0, StallF, StallD, StallE, FlushM, MultBusy, FlushE}, 16'b111100);
    step();
    MultStartE = 1'b0;
    for (int i = 1; i <= 31; i++) begin
      #1 check_eq($sformatf("mult_c%0d", i),
                  {12'd0, StallF, StallD, StallE, FlushM, MultBusy}, 16'b11111);
      step();
    end
    MultComplete = 1'b1;
    #1 check_eq("mult_c32_busy", 16'(MultBusy), 16'd1);
    step();
    MultComplete = 1'b0;
    HiLoReadD = 1'b1;
    #1 check_eq("mult_c33_done", {13'd0, MultBusy, StallE, StallD}, 16'b001);
    check_eq("mult_c33_flushm", 16'(FlushM), 16'd0);
    step();
    #1 check_eq("mult_c34_idle", {13'd0, MultBusy, StallE, StallD}, 16'b000);
    clear_inputs();
    step();

    // HI/LO read and load-use during BUSY: stall wins, no flush
    MultStartE = 1'b1;
    step();
    MultStartE = 1'b0;
    HiLoReadD = 1'b1;
    #1 check_eq("hilo_busy", {13'd0, StallD, StallE, MultBusy}, 16'b111);
    MemToRegE = 1'b1; WriteRegE = 5'd8; RtD = 5'd8;
    #1 check_eq("lw_during_busy", {13'd0, StallD, FlushE, FlushM}, 16'b101);
    MemToRegE = 1'b0; WriteRegE = 5'd0; RtD = 5'd0;
    for (int i = 2; i <= 10; i++) step();

    // async reset mid-multiply at cycle 10
    rst = 1'b1;
    #1 check_eq("rst_mid_busy", {14'd0, MultBusy, StallE}, 16'b00);
    check_eq("rst_mid_stalld", 16'(StallD), 16'd0);
    #2 rst = 1'b0;
    step();
    #1 check_eq("post_rst_no_done_a", {13'd0, StallD, StallE, MultBusy}, 16'b000);
    step();
    #1 check_eq("post_rst_no_done_b", {13'd0, StallD, StallE, MultBusy}, 16'b000);
    clear_inputs();
    step();

    // start and complete in the same cycle: DONE without BUSY
    MultStartE = 1'b1; MultComplete = 1'b1;
    #1 check_eq("mult_fast_c0", {14'd0, StallE, StallD}, 16'b00);
    step();
    clear_inputs();
    HiLoReadD = 1'b1;
    #1 check_eq("mult_fast_done", {13'd0, MultBusy, StallE, StallD}, 16'b001);
    step();
    #1 check_eq("mult_fast_idle", {13'd0, MultBusy, StallE, StallD}, 16'b000);
    clear_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
